// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control indices, default widths and issue-queue entry records
package alu_pkg;
    localparam int ALU_ADD = 0;
    localparam int ALU_LD  = 1;
    localparam int ALU_ST  = 2;
    localparam int ALU_SUB = 3;
    localparam int ALU_MUL = 4;
    localparam int ALU_CMP = 5;
    localparam int ALU_MOV = 6;
    localparam int ALU_OR  = 7;
    localparam int ALU_AND = 8;
    localparam int ALU_NOT = 9;
    localparam int ALU_LSL = 10;
    localparam int ALU_LSR = 11;

    localparam int SIG_W  = 12;
    localparam int DATA_W = 16;
    localparam int IMM_W  = 5;
    localparam int TAG_W  = 4;

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } src_t;

    typedef struct packed {
        logic             valid;
        logic [SIG_W-1:0] alusignals;
        src_t             src1;
        src_t             src2;
        logic [IMM_W-1:0] immx;
        logic             isimmediate;
        logic [TAG_W-1:0] dest_tag;
    } entry_t;
endpackage

// File: rtl/iq_entry_wakeup.sv
// iq_entry_wakeup: captures a CDB broadcast into one pending source operand
module iq_entry_wakeup
    import alu_pkg::*;
(
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  src_t              src,
    output src_t              src_next
);
    logic hit;

    assign hit      = cdb_valid && !src.rdy && (src.tag == cdb_tag);
    assign src_next = hit ? '{rdy: 1'b1, tag: src.tag, val: cdb_value} : src;
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: collapsing reservation station feeding the ALU, oldest-ready-first issue.
// Define ALU_IQ_WAKEUP_ISSUE_EN to let an entry issue in the same cycle its last operand is broadcast.
module alu_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = alu_pkg::TAG_W,
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int SIG_W  = alu_pkg::SIG_W,
    parameter int IMM_W  = alu_pkg::IMM_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [SIG_W-1:0]           disp_alusignals,
    input  logic [DATA_W-1:0]          disp_src1_val,
    input  logic [DATA_W-1:0]          disp_src2_val,
    input  logic                       disp_src1_rdy,
    input  logic                       disp_src2_rdy,
    input  logic [TAG_W-1:0]           disp_src1_tag,
    input  logic [TAG_W-1:0]           disp_src2_tag,
    input  logic [IMM_W-1:0]           disp_immx,
    input  logic                       disp_isimmediate,
    input  logic [TAG_W-1:0]           disp_dest_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_value,
    input  logic                       iss_ready,
    output logic                       iss_valid,
    output logic [SIG_W-1:0]           iss_alusignals,
    output logic [DATA_W-1:0]          iss_op1,
    output logic [DATA_W-1:0]          iss_op2,
    output logic [IMM_W-1:0]           iss_immx,
    output logic                       iss_isimmediate,
    output logic [TAG_W-1:0]           iss_dest_tag,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    import alu_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    entry_t         q    [DEPTH];
    entry_t         w    [DEPTH+1];
    entry_t         view [DEPTH];
    entry_t         n    [DEPTH];
    src_t           s1n  [DEPTH];
    src_t           s2n  [DEPTH];
    entry_t         de;
    src_t           d1, d2, d1n, d2n;
    logic [CW-1:0]  count, count_next, wr_idx;
    logic [DEPTH-1:0] elig;
    logic [IW-1:0]  sel;
    logic           disp_fire, iss_fire;

    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        iq_entry_wakeup u_s1 (.cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .src(q[g].src1), .src_next(s1n[g]));
        iq_entry_wakeup u_s2 (.cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .src(q[g].src2), .src_next(s2n[g]));
    end

    // an immediate-form op never waits on src2; dispatch sources also snoop the current broadcast
    assign d1 = '{rdy: disp_src1_rdy, tag: disp_src1_tag, val: disp_src1_val};
    assign d2 = '{rdy: disp_src2_rdy | disp_isimmediate, tag: disp_src2_tag, val: disp_src2_val};

    iq_entry_wakeup u_d1 (.cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .src(d1), .src_next(d1n));
    iq_entry_wakeup u_d2 (.cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .src(d2), .src_next(d2n));

    // woken copy of every slot plus an empty slot that shifts into the top on issue
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w[i]      = q[i];
            w[i].src1 = s1n[i];
            w[i].src2 = s2n[i];
`ifdef ALU_IQ_WAKEUP_ISSUE_EN
            view[i]   = w[i];
`else
            view[i]   = q[i];
`endif
        end
        w[DEPTH] = '0;
    end

    // oldest-first select over entries whose operands are both ready
    always_comb begin
        elig = '0;
        sel  = '0;
        for (int i = 0; i < DEPTH; i++)
            elig[i] = view[i].valid && view[i].src1.rdy && view[i].src2.rdy;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (elig[i]) sel = IW'(i);
    end

    assign iss_valid       = |elig;
    assign iss_fire        = iss_valid && iss_ready;
    assign disp_ready      = count < FULL;
    assign disp_fire       = disp_valid && disp_ready;
    assign occupancy       = count;
    assign iss_alusignals  = iss_valid ? view[sel].alusignals  : '0;
    assign iss_op1         = iss_valid ? view[sel].src1.val    : '0;
    assign iss_op2         = iss_valid ? view[sel].src2.val    : '0;
    assign iss_immx        = iss_valid ? view[sel].immx        : '0;
    assign iss_isimmediate = iss_valid ? view[sel].isimmediate : 1'b0;
    assign iss_dest_tag    = iss_valid ? view[sel].dest_tag    : '0;

    // build the dispatched entry record
    always_comb begin
        de             = '0;
        de.valid       = 1'b1;
        de.alusignals  = disp_alusignals;
        de.src1        = d1n;
        de.src2        = d2n;
        de.immx        = disp_immx;
        de.isimmediate = disp_isimmediate;
        de.dest_tag    = disp_dest_tag;
    end

    // compact above the issued slot, then append the new entry at the compacted tail
    always_comb begin
        wr_idx     = count - CW'(iss_fire);
        count_next = flush ? '0 : wr_idx + CW'(disp_fire);
        for (int i = 0; i < DEPTH; i++) begin
            n[i] = (iss_fire && i >= int'(sel)) ? w[i+1] : w[i];
            if (disp_fire && CW'(i) == wr_idx) n[i] = de;
            if (flush) n[i] = '0;
        end
    end

    // entry storage and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= n[i];
            count <= count_next;
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: scoreboard bench for alu_issue_queue (default build, optional same-cycle wakeup issue)
module tb_alu_issue_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [11:0] disp_alusignals = '0;
    logic [15:0] disp_src1_val = '0, disp_src2_val = '0;
    logic        disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
    logic [3:0]  disp_src1_tag = '0, disp_src2_tag = '0;
    logic [4:0]  disp_immx = '0;
    logic        disp_isimmediate = 1'b0;
    logic [3:0]  disp_dest_tag = '0;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [15:0] cdb_value = '0;
    logic        iss_ready = 1'b0;
    logic        iss_valid;
    logic [11:0] iss_alusignals;
    logic [15:0] iss_op1, iss_op2;
    logic [4:0]  iss_immx;
    logic        iss_isimmediate;
    logic [3:0]  iss_dest_tag;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;
    logic [47:0] sb[$];

    alu_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_alusignals(disp_alusignals),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_immx(disp_immx), .disp_isimmediate(disp_isimmediate), .disp_dest_tag(disp_dest_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .iss_ready(iss_ready), .iss_valid(iss_valid), .iss_alusignals(iss_alusignals),
        .iss_op1(iss_op1), .iss_op2(iss_op2), .iss_immx(iss_immx),
        .iss_isimmediate(iss_isimmediate), .iss_dest_tag(iss_dest_tag), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [11:0] sig, input logic [15:0] v1, input logic r1, input logic [3:0] t1,
                            input logic [15:0] v2, input logic r2, input logic [3:0] t2,
                            input logic [4:0] imm, input logic isimm, input logic [3:0] dest);
        disp_valid = 1'b1;
        disp_alusignals = sig;
        disp_src1_val = v1; disp_src1_rdy = r1; disp_src1_tag = t1;
        disp_src2_val = v2; disp_src2_rdy = r2; disp_src2_tag = t2;
        disp_immx = imm; disp_isimmediate = isimm; disp_dest_tag = dest;
        tick();
        disp_valid = 1'b0;
    endtask

    // every accepted issue must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && iss_valid && iss_ready) begin
            if (sb.size() == 0) check("unexpected_issue", 64'(iss_dest_tag) | 64'h100, 64'h0);
            else check("issue_bundle", {iss_alusignals, iss_op1, iss_op2, iss_dest_tag}, sb.pop_front());
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check("rst_occ", occupancy, 0);
        check("rst_disp_ready", disp_ready, 1);
        check("rst_iss_valid", iss_valid, 0);
        check("rst_iss_data", {iss_alusignals, iss_op1, iss_op2, iss_dest_tag}, 0);
        #10 rst = 1'b0;
        tick();

        // back-to-back ready add
        iss_ready = 1'b1;
        sb.push_back({12'h001, 16'h0005, 16'h0003, 4'd2});
        dispatch(12'h001, 16'h0005, 1, 0, 16'h0003, 1, 0, 0, 0, 4'd2);
        check("add_occ", occupancy, 1);
        check("add_iss_valid", iss_valid, 1);
        tick();
        check("add_drained_occ", occupancy, 0);
        check("add_drained_valid", iss_valid, 0);

        // sub waiting on tag 7
        sb.push_back({12'h008, 16'h0010, 16'h0003, 4'd3});
        dispatch(12'h008, 16'h0000, 0, 4'd7, 16'h0003, 1, 0, 0, 0, 4'd3);
        check("sub_wait_occ", occupancy, 1);
        check("sub_wait_valid", iss_valid, 0);
        tick();
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 16'h0010;
        #1;
`ifdef ALU_IQ_WAKEUP_ISSUE_EN
        check("sub_bcast_valid", iss_valid, 1);
        tick();
        cdb_valid = 1'b0;
`else
        check("sub_bcast_valid", iss_valid, 0);
        tick();
        cdb_valid = 1'b0;
        check("sub_woken_valid", iss_valid, 1);
        tick();
`endif
        check("sub_done_occ", occupancy, 0);

        // fill to capacity with issue blocked
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back({12'h080, 16'(16'h0100 + i), 16'(16'h0200 + i), 4'(8 + i)});
            dispatch(12'h080, 16'(16'h0100 + i), 1, 0, 16'(16'h0200 + i), 1, 0, 0, 0, 4'(8 + i));
        end
        check("full_occ", occupancy, 4);
        check("full_disp_ready", disp_ready, 0);
        dispatch(12'h001, 16'hdead, 1, 0, 16'hbeef, 1, 0, 0, 0, 4'd15);
        check("full_reject_occ", occupancy, 4);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        check("one_issue_occ", occupancy, 3);
        check("one_issue_disp_ready", disp_ready, 1);
        iss_ready = 1'b1;
        repeat (3) tick();
        check("full_drained_occ", occupancy, 0);

        // younger ready ops overtake an older waiting one
        iss_ready = 1'b0;
        dispatch(12'h001, 16'h0000, 0, 4'd5, 16'h0001, 1, 0, 0, 0, 4'd4);
        dispatch(12'h080, 16'h0011, 1, 0, 16'h0022, 1, 0, 0, 0, 4'd5);
        dispatch(12'h100, 16'h0033, 1, 0, 16'h0044, 1, 0, 0, 0, 4'd6);
        sb.push_back({12'h080, 16'h0011, 16'h0022, 4'd5});
        sb.push_back({12'h100, 16'h0033, 16'h0044, 4'd6});
        iss_ready = 1'b1;
        repeat (2) tick();
        check("ooo_occ", occupancy, 1);
        check("ooo_wait_valid", iss_valid, 0);
        sb.push_back({12'h001, 16'h00ff, 16'h0001, 4'd4});
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_value = 16'h00ff;
        tick();
        cdb_valid = 1'b0;
        tick();
        check("ooo_done_occ", occupancy, 0);

        // dispatch-time bypass from the CDB
        sb.push_back({12'h040, 16'h0007, 16'h1234, 4'd7});
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 16'h1234;
        dispatch(12'h040, 16'h0007, 1, 0, 16'h0000, 0, 4'd3, 0, 0, 4'd7);
        cdb_valid = 1'b0;
        check("bypass_valid", iss_valid, 1);
        tick();
        check("bypass_done_occ", occupancy, 0);

        // immediate form ignores src2 readiness
        sb.push_back({12'h001, 16'h000a, 16'h0000, 4'd8});
        dispatch(12'h001, 16'h000a, 1, 0, 16'h0000, 0, 4'd9, 5'h15, 1, 4'd8);
        check("imm_valid", iss_valid, 1);
        check("imm_immx", iss_immx, 5'h15);
        check("imm_flag", iss_isimmediate, 1);
        tick();

        // simultaneous dispatch and issue keep occupancy steady
        iss_ready = 1'b0;
        sb.push_back({12'h200, 16'h0a0a, 16'h0b0b, 4'd10});
        dispatch(12'h200, 16'h0a0a, 1, 0, 16'h0b0b, 1, 0, 0, 0, 4'd10);
        iss_ready = 1'b1;
        sb.push_back({12'h400, 16'h0c0c, 16'h0d0d, 4'd11});
        dispatch(12'h400, 16'h0c0c, 1, 0, 16'h0d0d, 1, 0, 0, 0, 4'd11);
        check("dispiss_occ", occupancy, 1);
        tick();
        check("dispiss_done_occ", occupancy, 0);

        // flush empties the queue at the next edge
        iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) dispatch(12'h001, 16'(i), 1, 0, 16'(i), 1, 0, 0, 0, 4'(i));
        check("pre_flush_occ", occupancy, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_occ", occupancy, 0);
        check("flush_valid", iss_valid, 0);

        // asynchronous reset clears without a clock edge
        for (int i = 0; i < 2; i++) dispatch(12'h002, 16'h1111, 1, 0, 16'h2222, 1, 0, 0, 0, 4'd1);
        check("pre_rst_occ", occupancy, 2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_occ", occupancy, 0);
        check("async_rst_valid", iss_valid, 0);
        check("async_rst_disp_ready", disp_ready, 1);
        check("async_rst_op1", iss_op1, 0);
        #3 rst = 1'b0;
        tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
